// File: rtl/velocity_converter_ctrl.sv
// Velocity poll sequencer: turns latched speed/pitch/heading into a Q16.16 v_x/v_y/v_z
// vector using two lookups on a shared sin/cos unit, with a watchdog on that handshake.
module velocity_converter_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  request_velocities,
  input  logic [DATA_WIDTH-1:0] speed,
  input  logic [DATA_WIDTH-1:0] pitch,
  input  logic [DATA_WIDTH-1:0] heading,
  output logic                  velocities_ready,
  output logic [DATA_WIDTH-1:0] v_x,
  output logic [DATA_WIDTH-1:0] v_y,
  output logic [DATA_WIDTH-1:0] v_z,
  output logic                  trig_req,
  output logic [DATA_WIDTH-1:0] trig_angle,
  input  logic                  trig_ack,
  input  logic [DATA_WIDTH-1:0] trig_sin,
  input  logic [DATA_WIDTH-1:0] trig_cos,
  output logic                  busy,
  output logic                  overrun,
  output logic                  trig_timeout
);

  localparam int PW   = 2 * DATA_WIDTH;
  localparam int FRAC = 16;
  localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]         WD_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PITCH, S_MUL_PITCH, S_WAIT_HDG, S_MUL_HDG, S_DONE
  } state_e;

  function automatic logic signed [PW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return $signed({{DATA_WIDTH{v[DATA_WIDTH-1]}}, v});
  endfunction

  // Q16.16 x Q16.16 keeps the middle word of the double-width product; upper bits wrap.
  function automatic logic [DATA_WIDTH-1:0] qmul(input logic signed [PW-1:0] a,
                                                 input logic signed [PW-1:0] b);
    logic signed [PW-1:0] p;
    p = a * b;
    return p[DATA_WIDTH+FRAC-1:FRAC];
  endfunction

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] speed_q, speed_d, pitch_q, pitch_d, heading_q, heading_d;
  logic [DATA_WIDTH-1:0] sin_q, sin_d, cos_q, cos_d;
  logic [DATA_WIDTH-1:0] vy_tmp_q, vy_tmp_d, h_q, h_d;
  logic [DATA_WIDTH-1:0] vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
  logic [CW-1:0]         wd_q, wd_d;
  logic                  timeout_q, timeout_d, overrun_q, overrun_d;

  logic signed [PW-1:0]  speed_ext;
  logic [DATA_WIDTH-1:0] vy_prod, h_prod, vx_prod, hc_prod;

  assign speed_ext = $signed({{DATA_WIDTH{1'b0}}, speed_q});
  assign vy_prod   = qmul(speed_ext, sext(sin_q));
  assign h_prod    = qmul(speed_ext, sext(cos_q));
  assign vx_prod   = qmul(sext(h_q), sext(sin_q));
  assign hc_prod   = qmul(sext(h_q), sext(cos_q));

  // NOTE: every state register updates with <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      speed_q   <= '0;
      pitch_q   <= '0;
      heading_q <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      vy_tmp_q  <= '0;
      h_q       <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      vz_q      <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      pitch_q   <= pitch_d;
      heading_q <= heading_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      vy_tmp_q  <= vy_tmp_d;
      h_q       <= h_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      vz_q      <= vz_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: each _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    pitch_d   = pitch_q;
    heading_d = heading_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    vy_tmp_d  = vy_tmp_q;
    h_d       = h_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    vz_d      = vz_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    overrun_d = request_velocities && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: if (request_velocities) begin
        speed_d   = speed;
        pitch_d   = pitch;
        heading_d = heading;
        wd_d      = '0;
        state_d   = S_WAIT_PITCH;
      end
      S_WAIT_PITCH, S_WAIT_HDG: begin
        if (trig_ack) begin
          sin_d   = trig_sin;
          cos_d   = trig_cos;
          state_d = (state_q == S_WAIT_PITCH) ? S_MUL_PITCH : S_MUL_HDG;
        end else if (wd_q == WD_LAST) begin
          // Abort: results stay as they were, the poll still completes.
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_MUL_PITCH: begin
        vy_tmp_d = vy_prod;
        h_d      = h_prod;
        wd_d     = '0;
        state_d  = S_WAIT_HDG;
      end
      S_MUL_HDG: begin
        vx_d    = vx_prod;
        vy_d    = vy_tmp_q;
        vz_d    = (hc_prod == MIN_NEG) ? ~MIN_NEG : -hc_prod;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign trig_req         = (state_q == S_WAIT_PITCH) || (state_q == S_WAIT_HDG);
  assign trig_angle       = (state_q == S_WAIT_PITCH) ? pitch_q :
                            (state_q == S_WAIT_HDG)   ? heading_q : '0;
  assign busy             = (state_q != S_IDLE);
  assign velocities_ready = (state_q == S_DONE);
  assign trig_timeout     = timeout_q;
  assign overrun          = overrun_q;
  assign v_x              = vx_q;
  assign v_y              = vy_q;
  assign v_z              = vz_q;

endmodule

// File: tb/tb_velocity_converter_ctrl.sv
// Bench for velocity_converter_ctrl: a behavioural trig unit plus a scoreboard of expected
// velocity vectors, timeout flags and latencies, popped on each velocities_ready pulse.
module tb_velocity_converter_ctrl;
  localparam int W  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         request_velocities = 1'b0;
  logic [W-1:0] speed = '0, pitch = '0, heading = '0;
  logic         velocities_ready, trig_req, busy, overrun, trig_timeout;
  logic [W-1:0] v_x, v_y, v_z, trig_angle;
  logic         trig_ack = 1'b0;
  logic [W-1:0] trig_sin = '0, trig_cos = '0;

  velocity_converter_ctrl #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .request_velocities(request_velocities),
    .speed(speed), .pitch(pitch), .heading(heading),
    .velocities_ready(velocities_ready), .v_x(v_x), .v_y(v_y), .v_z(v_z),
    .trig_req(trig_req), .trig_angle(trig_angle), .trig_ack(trig_ack),
    .trig_sin(trig_sin), .trig_cos(trig_cos),
    .busy(busy), .overrun(overrun), .trig_timeout(trig_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] vx, vy, vz;
    logic         to;
    int           lat;
    int           t0;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_cmp = 0, n_err = 0;
  int           cyc = 0, ready_cnt = 0, overrun_cnt = 0, ack_cnt = 0;
  logic [W-1:0] last_vx = '0, last_vy = '0, last_vz = '0;

  always @(posedge clk) cyc++;

  // ---------------- trig unit model ----------------
  int           ack_delay = 0, ack_budget = -1, wcnt = 0;
  bit           chk_stable = 0, stray_ack = 0, acked_prev = 0;
  logic [W-1:0] angle_first;

  task automatic trig_lut(input logic [W-1:0] a, output logic [W-1:0] s, output logic [W-1:0] c);
    case (a)
      32'h0000_0000: begin s = 32'h0000_0000; c = 32'h0001_0000; end
      32'h001E_0000: begin s = 32'h0000_8000; c = 32'h0000_DDB4; end
      32'h002D_0000: begin s = 32'h0000_B505; c = 32'h0000_B505; end
      32'h005A_0000: begin s = 32'h0001_0000; c = 32'h0000_0000; end
      32'h00B4_0000: begin s = 32'h0000_0000; c = 32'hFFFF_0000; end
      32'h010E_0000: begin s = 32'hFFFF_0000; c = 32'h0000_0000; end
      32'hFFE2_0000: begin s = 32'hFFFF_8000; c = 32'h0000_DDB4; end
      default:       begin s = 32'h0000_0000; c = 32'h0001_0000; end
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_stable && acked_prev) begin
      n_cmp++;
      if (trig_req !== 1'b0) begin
        n_err++;
        $display("FAIL trig_req_drop: trig_req=%b required 0 the cycle after ack", trig_req);
      end
    end
    acked_prev = 0;
    if (trig_req) begin
      if (wcnt == 0) angle_first = trig_angle;
      else if (chk_stable) begin
        n_cmp++;
        if (trig_angle !== angle_first) begin
          n_err++;
          $display("FAIL trig_angle_stable: got %h required %h", trig_angle, angle_first);
        end
      end
      if (wcnt >= ack_delay && ack_budget != 0) begin
        trig_lut(trig_angle, trig_sin, trig_cos);
        trig_ack   = 1'b1;
        wcnt       = 0;
        acked_prev = 1;
        ack_cnt++;
        if (ack_budget > 0) ack_budget--;
      end else begin
        trig_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt     = 0;
      trig_ack = stray_ack;
      if (stray_ack) begin
        trig_sin = 32'h1234_5678;
        trig_cos = 32'h8765_4321;
      end
    end
  end

  // ---------------- output monitor / scoreboard pop ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (overrun) overrun_cnt++;
      if (trig_timeout && !velocities_ready) begin
        n_cmp++; n_err++;
        $display("FAIL timeout_alone: trig_timeout=1 without velocities_ready");
      end
      if (velocities_ready) begin
        ready_cnt++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_ready: velocities_ready with empty scoreboard");
        end else begin
          mon_e = sb.pop_front();
          n_cmp += 5;
          if (v_x !== mon_e.vx) begin
            n_err++; $display("FAIL v_x: got %h required %h", v_x, mon_e.vx);
          end
          if (v_y !== mon_e.vy) begin
            n_err++; $display("FAIL v_y: got %h required %h", v_y, mon_e.vy);
          end
          if (v_z !== mon_e.vz) begin
            n_err++; $display("FAIL v_z: got %h required %h", v_z, mon_e.vz);
          end
          if (trig_timeout !== mon_e.to) begin
            n_err++; $display("FAIL trig_timeout: got %b required %b", trig_timeout, mon_e.to);
          end
          if (cyc - mon_e.t0 != mon_e.lat) begin
            n_err++; $display("FAIL latency: got %0d required %0d", cyc - mon_e.t0, mon_e.lat);
          end
        end
      end
    end
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [W-1:0] q_mul(input logic [W-1:0] a, input bit a_signed,
                                         input logic [W-1:0] b);
    longint       la, lb;
    logic [63:0]  p;
    la = a_signed ? longint'($signed(a)) : longint'({32'b0, a});
    lb = longint'($signed(b));
    p  = la * lb;
    return p[47:16];
  endfunction

  task automatic model(input logic [W-1:0] spd, p, h,
                       output logic [W-1:0] vx, vy, vz);
    logic [W-1:0] sp, cp, sh, ch, hh, t;
    trig_lut(p, sp, cp);
    trig_lut(h, sh, ch);
    vy = q_mul(spd, 0, sp);
    hh = q_mul(spd, 0, cp);
    vx = q_mul(hh, 1, sh);
    t  = q_mul(hh, 1, ch);
    vz = (t == 32'h8000_0000) ? 32'h7FFF_FFFF : -t;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [W-1:0] spd, p, h, input logic [W-1:0] evx, evy, evz,
                       input logic eto, input int elat);
    exp_t e;
    @(negedge clk);
    e.vx = eto ? last_vx : evx;
    e.vy = eto ? last_vy : evy;
    e.vz = eto ? last_vz : evz;
    e.to = eto; e.lat = elat; e.t0 = cyc;
    sb.push_back(e);
    last_vx = e.vx; last_vy = e.vy; last_vz = e.vz;
    speed = spd; pitch = p; heading = h;
    request_velocities = 1'b1;
    @(negedge clk);
    request_velocities = 1'b0;
    speed = $urandom; pitch = $urandom; heading = $urandom;
  endtask

  task automatic issue_model(input logic [W-1:0] spd, p, h, input int elat);
    logic [W-1:0] vx, vy, vz;
    model(spd, p, h, vx, vy, vz);
    issue(spd, p, h, vx, vy, vz, 1'b0, elat);
  endtask

  task automatic wait_ready(input int target, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ready_cnt >= target) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL ready_wait: ready_cnt=%0d required %0d within %0d cycles", ready_cnt, target, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if ({busy, trig_req, velocities_ready, overrun, trig_timeout} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: busy/req/ready/ovr/to=%b required 00000",
                        {busy, trig_req, velocities_ready, overrun, trig_timeout});
    end
    if ({v_x, v_y, v_z} !== '0) begin
      n_err++; $display("FAIL reset_v: v=%h %h %h required 0", v_x, v_y, v_z);
    end
    if (trig_angle !== '0) begin
      n_err++; $display("FAIL reset_angle: got %h required 0", trig_angle);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    issue(32'h0014_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFEC_0000, 1'b0, 5);
    wait_ready(ready_cnt + 1, 20);
    issue(32'h0014_0000, 32'h001E_0000, 32'h005A_0000,
          32'h0011_5210, 32'h000A_0000, 32'h0, 1'b0, 5);
    wait_ready(ready_cnt + 1, 20);
  endtask

  task automatic test_boundaries();
    // h wraps to 0x8000_0000, so -(h*cos 0) must saturate
    issue(32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 1'b0, 5);
    wait_ready(ready_cnt + 1, 20);
    // v_y truncates to the low product word
    issue(32'hFFFF_0000, 32'h005A_0000, 32'h0, 32'h0, 32'hFFFF_0000, 32'h0, 1'b0, 5);
    wait_ready(ready_cnt + 1, 20);
    issue_model(32'h0003_8000, 32'hFFE2_0000, 32'h002D_0000, 5);
    wait_ready(ready_cnt + 1, 20);
    issue_model(32'h0123_4567, 32'h00B4_0000, 32'h010E_0000, 5);
    wait_ready(ready_cnt + 1, 20);
  endtask

  task automatic test_ack_delay();
    int a0;
    ack_delay = 3; chk_stable = 1; a0 = ack_cnt;
    issue_model(32'h0014_0000, 32'h001E_0000, 32'h002D_0000, 11);
    wait_ready(ready_cnt + 1, 30);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ack_cnt - a0 != 2) begin
      n_err++; $display("FAIL ack_count: got %0d required 2", ack_cnt - a0);
    end
    ack_delay = 0; chk_stable = 0;
  endtask

  task automatic test_stray_ack();
    stray_ack = 1;
    issue_model(32'h0002_0000, 32'h002D_0000, 32'h005A_0000, 5);
    wait_ready(ready_cnt + 1, 20);
    @(negedge clk);
    stray_ack = 0;
  endtask

  task automatic test_timeout();
    ack_budget = 0; chk_stable = 1;
    issue(32'h0005_0000, 32'h001E_0000, 32'h0, '0, '0, '0, 1'b1, TO + 1);
    wait_ready(ready_cnt + 1, 30);
    @(negedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_idle: busy=%b required 0", busy);
    end
    ack_budget = 1;
    issue(32'h0005_0000, 32'h001E_0000, 32'h0, '0, '0, '0, 1'b1, TO + 3);
    wait_ready(ready_cnt + 1, 30);
    ack_budget = -1; chk_stable = 0;
    issue_model(32'h0005_0000, 32'h001E_0000, 32'h0, 5);
    wait_ready(ready_cnt + 1, 20);
  endtask

  task automatic test_overrun();
    int  o0, r0;
    bit  found = 0;
    ack_delay = 2; o0 = overrun_cnt; r0 = ready_cnt;
    issue_model(32'h0014_0000, 32'h001E_0000, 32'h005A_0000, 9);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (trig_req && trig_angle == 32'h005A_0000) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL overrun_reach_hdg: WAIT_HDG not observed");
    end
    speed = 32'h0099_0000; pitch = 32'h0; heading = 32'h0;
    request_velocities = 1'b1;
    @(negedge clk);
    request_velocities = 1'b0;
    wait_ready(r0 + 1, 30);
    repeat (10) @(negedge clk);
    n_cmp += 2;
    if (overrun_cnt - o0 != 1) begin
      n_err++; $display("FAIL overrun_count: got %0d required 1", overrun_cnt - o0);
    end
    if (ready_cnt - r0 != 1) begin
      n_err++; $display("FAIL ready_count: got %0d required 1", ready_cnt - r0);
    end
    ack_delay = 0;
  endtask

  task automatic test_back_to_back();
    int o0, r0;
    o0 = overrun_cnt; r0 = ready_cnt;
    issue_model(32'h0007_0000, 32'h002D_0000, 32'h002D_0000, 5);
    wait_ready(ready_cnt + 1, 20);
    // still in the DONE cycle: this request must be dropped and flagged
    request_velocities = 1'b1;
    issue_model(32'h0001_0000, 32'h005A_0000, 32'h00B4_0000, 5);
    wait_ready(ready_cnt + 1, 20);
    issue_model(32'h0010_0000, 32'hFFE2_0000, 32'h010E_0000, 5);
    wait_ready(ready_cnt + 1, 20);
    repeat (4) @(negedge clk);
    n_cmp += 2;
    if (overrun_cnt - o0 != 1) begin
      n_err++; $display("FAIL done_overrun: got %0d required 1", overrun_cnt - o0);
    end
    if (ready_cnt - r0 != 3) begin
      n_err++; $display("FAIL b2b_ready_count: got %0d required 3", ready_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    issue_model(32'h0014_0000, 32'h001E_0000, 32'h005A_0000, 5);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL mid_busy: busy=%b required 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp += 2;
    if ({trig_req, busy, velocities_ready} !== 3'b0) begin
      n_err++; $display("FAIL async_reset_ctrl: req/busy/ready=%b required 000",
                        {trig_req, busy, velocities_ready});
    end
    if ({v_x, v_y, v_z} !== '0) begin
      n_err++; $display("FAIL async_reset_v: v=%h %h %h required 0", v_x, v_y, v_z);
    end
    sb.delete();
    last_vx = '0; last_vy = '0; last_vz = '0;
    @(negedge clk);
    reset_n = 1'b1;
    issue_model(32'h0014_0000, 32'h002D_0000, 32'h001E_0000, 5);
    wait_ready(ready_cnt + 1, 20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ack_delay();
    test_stray_ack();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d results never produced", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/velocity_converter_ctrl.md
Name: velocity_converter_ctrl

Overview:
- Sequencer that services the plane model's velocity poll (request_velocities / velocities_ready).
- Converts the latched speed, pitch and heading into Q16.16 v_x, v_y, v_z.
- Computes these by sequencing two lookups on a shared sin/cos unit, then doing fixed-point multiplies.
- Sits between the plane state block and the trig unit; owns the trig handshake and a watchdog on it.

Parameters:
- DATA_WIDTH, 32, width of all fixed-point values (Q16.16).
- TIMEOUT_CYCLES, 64, maximum cycles to wait for trig_ack before aborting a conversion.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- request_velocities  in  1  single-cycle start pulse from plane state.
- speed  in  32  unsigned Q16.16, per sec.
- pitch  in  32  signed Q16.16 deg, range [-180,180].
- heading  in  32  unsigned Q16.16 deg, range [0,360).
- velocities_ready  out  1  single-cycle completion pulse.
- v_x  out  32  signed Q16.16, right.
- v_y  out  32  signed Q16.16, up.
- v_z  out  32  signed Q16.16, into screen.
- trig_req  out  1  lookup request, level.
- trig_angle  out  32  Q16.16 deg sent to the trig unit.
- trig_ack  in  1  trig result valid this cycle.
- trig_sin  in  32  signed Q16.16.
- trig_cos  in  32  signed Q16.16.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  pulse when request_velocities arrives while busy.
- trig_timeout  out  1  pulse when the watchdog aborts a conversion.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; v_x, v_y, v_z = 0; all pulses, trig_req and busy = 0; trig_angle = 0; watchdog counter = 0. Reset mid-conversion drops trig_req immediately and discards partial results.
- States: IDLE, WAIT_PITCH, MUL_PITCH, WAIT_HDG, MUL_HDG, DONE.
- IDLE:
  - On request_velocities: latch speed, pitch, heading into internal registers, then go to WAIT_PITCH.
  - Later changes on the inputs do not affect the conversion.
- WAIT_PITCH:
  - trig_req=1, trig_angle=latched pitch.
  - On the cycle trig_ack=1, sample sin/cos and go to MUL_PITCH.
  - trig_req is held high and trig_angle held stable until ack. trig_req drops the cycle after ack.
- MUL_PITCH:
  - vy_tmp = (speed × sin_p)[47:16]; h = (speed × cos_p)[47:16].
  - Products are 64-bit signed; speed is zero-extended as a positive value.
  - Go to WAIT_HDG.
- WAIT_HDG: same handshake with trig_angle = latched heading, then go to MUL_HDG.
- MUL_HDG:
  - vx_tmp = (h × sin_h)[47:16]; vz_tmp = −(h × cos_h)[47:16].
  - Negating 0x8000_0000 saturates to 0x7FFF_FFFF.
  - Go to DONE.
- DONE:
  - v_x, v_y, v_z update together from the temporaries.
  - velocities_ready=1 for exactly this cycle, then go to IDLE.
  - Outputs hold their values until the next successful DONE.
- Latency: when trig_ack arrives in the first cycle of each trig_req, velocities_ready asserts 5 cycles after the request cycle. Each extra ack wait cycle adds 1.
- Watchdog:
  - The counter clears on entry to each WAIT state and increments every cycle without ack.
  - When it reaches TIMEOUT_CYCLES−1 with no ack: drop trig_req, go to DONE, leave v_* unchanged, and pulse trig_timeout alongside velocities_ready.
  - This guarantees the plane state block never deadlocks.
- Overrun:
  - request_velocities in any non-IDLE state is ignored and pulses overrun the next cycle.
  - A request in DONE is also ignored.
- trig_ack while not in a WAIT state is ignored.
- Overflow: product bits above [47:16] are truncated, with no saturation except the negation case.

Test Plan:
- speed=0x0014_0000, pitch=0, heading=0, trig model sin0=0 cos0=0x0001_0000, 0-cycle ack -> velocities_ready 5 cycles after request; v_x=0, v_y=0, v_z=0xFFEC_0000.
- speed=20, pitch=30 (sin=0x0000_8000, cos=0x0000_DDB4), heading=90 (sin=0x0001_0000, cos=0) -> v_y=0x000A_0000, v_x=0x0011_5210, v_z=0.
- trig ack delayed 3 cycles per lookup -> ready at cycle 11; trig_req stays high and trig_angle stable throughout each wait; ack sampled exactly once.
- trig_ack never asserted, TIMEOUT_CYCLES=8 -> trig_timeout and velocities_ready pulse together; v_* keep previous values; FSM returns to IDLE.
- Second request_velocities during WAIT_HDG -> overrun pulses once; the result is that of the first request only; exactly one velocities_ready.
- reset_n low in MUL_PITCH -> trig_req, busy and v_* go to 0 asynchronously; a new request after release completes normally.
